// File: rtl/change_dispenser_if.sv
// Payout request / coin-eject bundle between the vending controller and the change dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 7,
  parameter int INV_W = 4
);
  logic             start;
  logic [AMT_W-1:0] amount;
  logic             refill;
  logic             coin_q;
  logic             coin_d;
  logic             coin_n;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] q_left;
  logic [INV_W-1:0] d_left;
  logic [INV_W-1:0] n_left;

  modport master (
    output start, amount, refill,
    input  coin_q, coin_d, coin_n, busy, done, fault, remaining, q_left, d_left, n_left
  );

  modport slave (
    input  start, amount, refill,
    output coin_q, coin_d, coin_n, busy, done, fault, remaining, q_left, d_left, n_left
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout: quarters, then dimes, then nickels from finite inventories,
// one timed eject pulse per coin, done or fault when nothing more can be paid.
//
// state    | meaning
// IDLE     | waiting for start; refill reloads inventories
// SELECT   | pick next coin (or finish / fault)
// PULSE    | chosen coin solenoid held high
// GAP      | all solenoids low between ejects
// DONE     | one-cycle done pulse
// FAULT    | owed amount cannot be paid; waits for refill
module change_dispenser #(
  parameter int AMT_W        = 7,
  parameter int INV_W        = 4,
  parameter int INV_INIT     = 10,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_PULSE  = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  // Timer only ever holds PULSE_CYCLES-1 or GAP_CYCLES-1 down to zero.
  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [INV_W-1:0] INV_FULL   = INV_W'(INV_INIT);
  localparam logic [AMT_W-1:0] Q_VAL      = AMT_W'(5);
  localparam logic [AMT_W-1:0] D_VAL      = AMT_W'(2);
  localparam logic [AMT_W-1:0] N_VAL      = AMT_W'(1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             coin_q, coin_d, coin_n, busy, done, fault;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] q_left, d_left, n_left;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      coin_q    <= 1'b0;
      coin_d    <= 1'b0;
      coin_n    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
      q_left    <= INV_FULL;
      d_left    <= INV_FULL;
      n_left    <= INV_FULL;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.refill) begin
            q_left <= INV_FULL;
            d_left <= INV_FULL;
            n_left <= INV_FULL;
          end
          if (bus.start) begin
            remaining <= bus.amount;
            busy      <= 1'b1;
            state     <= S_SELECT;
          end
        end
        S_SELECT: begin
          cnt <= PULSE_LOAD;
          if (remaining >= Q_VAL && q_left != '0) begin
            remaining <= remaining - Q_VAL;
            q_left    <= q_left - 1'b1;
            coin_q    <= 1'b1;
            state     <= S_PULSE;
          end else if (remaining >= D_VAL && d_left != '0) begin
            remaining <= remaining - D_VAL;
            d_left    <= d_left - 1'b1;
            coin_d    <= 1'b1;
            state     <= S_PULSE;
          end else if (remaining >= N_VAL && n_left != '0) begin
            remaining <= remaining - N_VAL;
            n_left    <= n_left - 1'b1;
            coin_n    <= 1'b1;
            state     <= S_PULSE;
          end else if (remaining == '0) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            fault <= 1'b1;
            state <= S_FAULT;
          end
        end
        S_PULSE: begin
          if (cnt == '0) begin
            coin_q <= 1'b0;
            coin_d <= 1'b0;
            coin_n <= 1'b0;
            cnt    <= GAP_LOAD;
            state  <= (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == '0) state <= S_SELECT;
          else           cnt   <= cnt - 1'b1;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_FAULT: begin
          // Restocking resumes the interrupted payout with the amount still owed.
          if (bus.refill) begin
            q_left <= INV_FULL;
            d_left <= INV_FULL;
            n_left <= INV_FULL;
            fault  <= 1'b0;
            state  <= S_SELECT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.coin_q    = coin_q;
  assign bus.coin_d    = coin_d;
  assign bus.coin_n    = coin_n;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.fault     = fault;
  assign bus.remaining = remaining;
  assign bus.q_left    = q_left;
  assign bus.d_left    = d_left;
  assign bus.n_left    = n_left;
endmodule
